mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: two-requester round-robin arbiter in front of a single shared word memory.
// Latency: request accepted in cycle T -> response valid in T+2; one transaction in flight.
// Backpressure: a held response (i_rsp_ready low) stalls all new grants until consumed.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-low reset
//   i_req_* / o_req_ready per-requester request channel, slice r belongs to requester r
//   o_rsp_valid / i_rsp_ready per-requester response handshake; rdata/err are shared
//   o_mem_* / i_mem_rdata shared memory port; o_mem_addr is a word index, read is combinational
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_S = 512
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [1:0]                i_req_valid,
  output logic [1:0]                o_req_ready,
  input  logic [2*ADDR_W-1:0]       i_req_addr,
  input  logic [2*DATA_W-1:0]       i_req_wdata,
  input  logic [2*(DATA_W/8)-1:0]   i_req_bmask,
  input  logic [1:0]                i_req_wren,
  output logic [1:0]                o_rsp_valid,
  input  logic [1:0]                i_rsp_ready,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic [(DATA_W/8)-1:0]     o_mem_bmask,
  output logic                      o_mem_wren,
  input  logic [DATA_W-1:0]         i_mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_S);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       bmask_q, bmask_d;
  logic                wren_q, wren_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Grant selection and the granted requester's payload
  logic                gnt_sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NB-1:0]       sel_bmask;
  logic                sel_wren;
  logic                sel_err;
  logic                req_fire;

  always_comb begin
    gnt_sel = 1'b0;
    if (i_req_valid == 2'b11) begin
      gnt_sel = rr_ptr_q;
    end else if (i_req_valid[1]) begin
      gnt_sel = 1'b1;
    end
  end

  assign sel_addr  = gnt_sel ? i_req_addr[2*ADDR_W-1:ADDR_W]  : i_req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_sel ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
  assign sel_bmask = gnt_sel ? i_req_bmask[2*NB-1:NB]         : i_req_bmask[NB-1:0];
  assign sel_wren  = i_req_wren[gnt_sel];

  // Misaligned or beyond the last word: flagged, memory is never touched
  assign sel_err = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= ADDR_LIMIT);

  // Ready is gated by reset so every output is quiet while reset is held
  assign req_fire = (state_q == ST_IDLE) && i_reset && i_req_valid[gnt_sel];

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      wren_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      wren_q   <= wren_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    wren_d   = wren_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          gnt_d   = gnt_sel;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          bmask_d = sel_bmask;
          wren_d  = sel_wren;
          err_d   = sel_err;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Writes and errored requests return zero data
        rdata_d  = (wren_q || err_q) ? '0 : i_mem_rdata;
        rr_ptr_d = ~gnt_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's ready can retire the response
        if (i_rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = 2'b00;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    o_mem_wren  = 1'b0;
    o_rsp_valid = 2'b00;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          o_req_ready = gnt_sel ? 2'b10 : 2'b01;
        end
      end
      ST_ACCESS: begin
        o_mem_addr  = addr_q >> 2;
        o_mem_wdata = wdata_q;
        o_mem_bmask = err_q ? '0 : bmask_q;
        o_mem_wren  = wren_q & ~err_q;
      end
      ST_RESP: begin
        o_rsp_valid = gnt_q ? 2'b10 : 2'b01;
        o_rsp_rdata = rdata_q;
        o_rsp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed bench for mem_arbiter with a byte-maskable behavioural memory.
// Latency: checks accept at T, memory strobe at T+1, response at T+2.
// Backpressure: exercises held responses, ignored foreign ready and reset mid-response.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_S = 512;
  localparam int NB     = DATA_W / 8;

  logic                 i_clk = 1'b0;
  logic                 i_reset;
  logic [1:0]           i_req_valid;
  logic [1:0]           o_req_ready;
  logic [2*ADDR_W-1:0]  i_req_addr;
  logic [2*DATA_W-1:0]  i_req_wdata;
  logic [2*NB-1:0]      i_req_bmask;
  logic [1:0]           i_req_wren;
  logic [1:0]           o_rsp_valid;
  logic [1:0]           i_rsp_ready;
  logic [DATA_W-1:0]    o_rsp_rdata;
  logic                 o_rsp_err;
  logic [ADDR_W-1:0]    o_mem_addr;
  logic [DATA_W-1:0]    o_mem_wdata;
  logic [NB-1:0]        o_mem_bmask;
  logic                 o_mem_wren;
  logic [DATA_W-1:0]    i_mem_rdata;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_S(ADDR_S)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_bmask(i_req_bmask), .i_req_wren(i_req_wren),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  // Behavioural memory: combinational read, byte-masked write on the clock edge
  logic [DATA_W-1:0] mem [0:ADDR_S-1];
  int wren_cnt = 0;

  initial begin
    for (int i = 0; i < ADDR_S; i++) mem[i] = '0;
  end

  assign i_mem_rdata = (o_mem_addr < 32'(ADDR_S)) ? mem[o_mem_addr[8:0]] : '0;

  always @(posedge i_clk) begin
    if (o_mem_wren) begin
      wren_cnt = wren_cnt + 1;
      if (o_mem_addr < 32'(ADDR_S)) begin
        for (int b = 0; b < NB; b++)
          if (o_mem_bmask[b]) mem[o_mem_addr[8:0]][b*8 +: 8] = o_mem_wdata[b*8 +: 8];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    bit          wren;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[11];

  // One complete transaction on requester v.r with per-cycle checks
  task automatic do_txn(input vec_t v, input int idx);
    int cyc;
    int wc0;
    string tag;
    bit exp_w;
    tag = $sformatf("v%0d", idx);
    exp_w = v.wren & ~v.exp_err;
    @(negedge i_clk);
    i_req_valid[v.r] = 1'b1;
    i_req_addr[v.r*ADDR_W +: ADDR_W] = v.addr;
    i_req_wdata[v.r*DATA_W +: DATA_W] = v.wdata;
    i_req_bmask[v.r*NB +: NB] = v.bmask;
    i_req_wren[v.r] = v.wren;
    #1;
    cyc = 0;
    while (!o_req_ready[v.r] && cyc < 20) begin
      @(negedge i_clk); #1; cyc++;
    end
    chk({tag, ".req_ready"}, 64'(o_req_ready), 64'(2'b01 << v.r));
    wc0 = wren_cnt;
    @(negedge i_clk);
    i_req_valid[v.r] = 1'b0;
    #1;
    chk({tag, ".mem_wren"},  64'(o_mem_wren), 64'(exp_w));
    chk({tag, ".mem_bmask"}, 64'(o_mem_bmask), 64'(v.exp_err ? 4'h0 : v.bmask));
    chk({tag, ".mem_addr"},  64'(o_mem_addr), 64'(v.addr >> 2));
    chk({tag, ".rsp_early"}, 64'(o_rsp_valid), 64'(0));
    @(negedge i_clk); #1;
    chk({tag, ".rsp_valid"}, 64'(o_rsp_valid), 64'(2'b01 << v.r));
    chk({tag, ".rsp_rdata"}, 64'(o_rsp_rdata), 64'(v.exp_rdata));
    chk({tag, ".rsp_err"},   64'(o_rsp_err), 64'(v.exp_err));
    chk({tag, ".wren_count"}, 64'(wren_cnt - wc0), 64'(exp_w));
    i_rsp_ready[v.r] = 1'b1;
    @(negedge i_clk);
    i_rsp_ready[v.r] = 1'b0;
    #1;
    chk({tag, ".rsp_done"}, 64'(o_rsp_valid), 64'(0));
  endtask

  task automatic wait_grant(input int r, input string tag);
    int cyc;
    cyc = 0;
    #1;
    while (!o_req_ready[r] && cyc < 20) begin
      @(negedge i_clk); #1; cyc++;
    end
    chk(tag, 64'(o_req_ready), 64'(2'b01 << r));
  endtask

  initial begin
    int gseq[$];
    int wc0;

    //          r  addr          wdata         bm    wr  rdata         err
    vecs[0]  = '{0, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1, 32'h0,        0};
    vecs[1]  = '{1, 32'h0000_0010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 32'h0000_0020, 32'hAABBCCDD, 4'hF, 1, 32'h0,        0};
    vecs[3]  = '{1, 32'h0000_0020, 32'h11223344, 4'h5, 1, 32'h0,        0};
    vecs[4]  = '{0, 32'h0000_0020, 32'h0,        4'hF, 0, 32'hAA22CC44, 0};
    vecs[5]  = '{1, 32'h0000_0802, 32'h12345678, 4'hF, 1, 32'h0,        1};
    vecs[6]  = '{0, 32'h0000_0800, 32'h0,        4'hF, 0, 32'h0,        1};
    vecs[7]  = '{1, 32'h0000_0013, 32'h0,        4'hF, 0, 32'h0,        1};
    vecs[8]  = '{0, 32'h0000_07FC, 32'h01020304, 4'hF, 1, 32'h0,        0};
    vecs[9]  = '{1, 32'h0000_07FC, 32'h0,        4'hF, 0, 32'h01020304, 0};
    vecs[10] = '{0, 32'h0000_0800, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1};

    i_reset = 1'b0;
    i_req_valid = 2'b11;
    i_req_addr = '0;
    i_req_wdata = '0;
    i_req_bmask = '0;
    i_req_wren = '0;
    i_rsp_ready = '0;
    #2;
    chk("reset.req_ready", 64'(o_req_ready), 64'(0));
    chk("reset.rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("reset.mem_wren",  64'(o_mem_wren), 64'(0));
    chk("reset.mem_addr",  64'(o_mem_addr), 64'(0));
    i_req_valid = 2'b00;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;

    // Contention: both requesters valid continuously, grants must alternate from 0
    @(negedge i_clk);
    i_req_addr = {32'h10, 32'h10};
    i_req_valid = 2'b11;
    i_rsp_ready = 2'b11;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("contend.not_both", 64'(o_req_ready == 2'b11), 64'(0));
      if (o_req_ready == 2'b01) gseq.push_back(0);
      else if (o_req_ready == 2'b10) gseq.push_back(1);
      @(negedge i_clk);
    end
    i_req_valid = 2'b00;
    repeat (3) @(negedge i_clk);
    i_rsp_ready = 2'b00;
    chk("contend.grants", 64'(gseq.size()), 64'(5));
    for (int k = 0; k < 4; k++)
      chk($sformatf("contend.g%0d", k), 64'((gseq.size() > k) ? gseq[k] : -1), 64'(k % 2));

    for (int i = 0; i < 11; i++) do_txn(vecs[i], i);

    // Backpressure: response to requester 0 held for 5 cycles, requester 1 waits
    @(negedge i_clk);
    i_req_addr[31:0] = 32'h10;
    i_req_wren = 2'b00;
    i_req_valid[0] = 1'b1;
    wait_grant(0, "bp.grant0");
    @(negedge i_clk);
    i_req_valid[0] = 1'b0;
    i_req_addr[63:32] = 32'h20;
    i_req_valid[1] = 1'b1;
    i_rsp_ready = 2'b10;
    @(negedge i_clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp.valid%0d", c), 64'(o_rsp_valid), 64'(2'b01));
      chk($sformatf("bp.rdata%0d", c), 64'(o_rsp_rdata), 64'(32'hDEADBEEF));
      chk($sformatf("bp.nogrant%0d", c), 64'(o_req_ready), 64'(0));
      @(negedge i_clk); #1;
    end
    i_rsp_ready = 2'b01;
    @(negedge i_clk);
    i_rsp_ready = 2'b00;
    #1;
    chk("bp.grant1", 64'(o_req_ready), 64'(2'b10));
    @(negedge i_clk);
    i_req_valid[1] = 1'b0;
    @(negedge i_clk); #1;
    chk("bp.rsp1_valid", 64'(o_rsp_valid), 64'(2'b10));
    chk("bp.rsp1_rdata", 64'(o_rsp_rdata), 64'(32'hAA22CC44));
    i_rsp_ready = 2'b10;
    @(negedge i_clk);
    i_rsp_ready = 2'b00;

    // Reset in RESP after a requester-0 grant (pointer now favours requester 1)
    @(negedge i_clk);
    i_req_addr[31:0] = 32'h10;
    i_req_valid[0] = 1'b1;
    wait_grant(0, "rst.grant0");
    @(negedge i_clk);
    i_req_valid[0] = 1'b0;
    @(negedge i_clk); #1;
    chk("rst.in_resp", 64'(o_rsp_valid), 64'(2'b01));
    i_reset = 1'b0;
    #1;
    chk("rst.rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("rst.rsp_rdata", 64'(o_rsp_rdata), 64'(0));
    chk("rst.rsp_err",   64'(o_rsp_err), 64'(0));
    chk("rst.req_ready", 64'(o_req_ready), 64'(0));
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("rst.no_resp", 64'(o_rsp_valid), 64'(0));
    i_req_addr = {32'h20, 32'h10};
    i_req_valid = 2'b11;
    #1;
    chk("rst.first_grant", 64'(o_req_ready), 64'(2'b01));
    wc0 = wren_cnt;
    @(negedge i_clk);
    i_req_valid = 2'b00;
    @(negedge i_clk); #1;
    chk("rst.rsp_after", 64'(o_rsp_valid), 64'(2'b01));
    chk("rst.rdata_after", 64'(o_rsp_rdata), 64'(32'hDEADBEEF));
    chk("rst.no_write", 64'(wren_cnt - wc0), 64'(0));
    i_rsp_ready = 2'b01;
    @(negedge i_clk);
    i_rsp_ready = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
